// File: rtl/cpu_control.sv
// Multicycle Moore control FSM for the RV32I MP2 core.
// Drives datapath mux selects, load enables, and the memory handshake.
// Also keeps a wrapping retired-instruction counter.
module cpu_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 br_en,
    input  logic                 mem_resp,
    input  logic [1:0]           mem_addr_lo,
    output logic [1:0]           pcmux_sel,
    output logic                 load_pc,
    output logic                 cmpmux_sel,
    output logic                 marmux_sel,
    output logic                 alumux1_sel,
    output logic [2:0]           alumux2_sel,
    output logic [2:0]           regfilemux_sel,
    output logic [2:0]           aluop,
    output logic [2:0]           cmpop,
    output logic                 load_mar,
    output logic                 load_mdr,
    output logic                 load_ir,
    output logic                 load_regfile,
    output logic                 load_mem_data_out,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [3:0]           mem_byte_enable,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpReg   = 7'b0110011;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSra = 3'd2;
    localparam logic [2:0] AluSub = 3'd3;
    localparam logic [2:0] AluSrl = 3'd5;

    localparam logic [2:0] CmpBlt  = 3'd4;
    localparam logic [2:0] CmpBltu = 3'd6;

    typedef enum logic [4:0] {
        StFetch1, StFetch2, StFetch3, StDecode,
        StImm, StReg, StBr, StLui, StAuipc, StJal, StJalr,
        StCalcAddr, StLd1, StLd2, StSt1, StSt2, StNop
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q;

    // Only funct7[5] distinguishes sub/sra; the rest of the field is don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // State and retired-instruction counter; reset wins over any pending mem_resp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch1;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_pc) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch1: state_d = StFetch2;
            StFetch2: if (mem_resp) state_d = StFetch3;
            StFetch3: state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpImm:           state_d = StImm;
                    OpReg:           state_d = StReg;
                    OpBr:            state_d = StBr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLoad, OpStore: state_d = StCalcAddr;
                    default:         state_d = StNop;
                endcase
            end
            StCalcAddr: state_d = (opcode == OpStore) ? StSt1 : StLd1;
            StLd1:      if (mem_resp) state_d = StLd2;
            StSt1:      if (mem_resp) state_d = StSt2;
            StImm, StReg, StBr, StLui, StAuipc, StJal, StJalr, StLd2, StSt2, StNop:
                state_d = StFetch1;
            default:    state_d = StFetch1;
        endcase
    end

    // Moore outputs; everything forced low while reset is asserted.
    always_comb begin
        pcmux_sel         = 2'd0;
        load_pc           = 1'b0;
        cmpmux_sel        = 1'b0;
        marmux_sel        = 1'b0;
        alumux1_sel       = 1'b0;
        alumux2_sel       = 3'd0;
        regfilemux_sel    = 3'd0;
        aluop             = AluAdd;
        cmpop             = 3'd0;
        load_mar          = 1'b0;
        load_mdr          = 1'b0;
        load_ir           = 1'b0;
        load_regfile      = 1'b0;
        load_mem_data_out = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_byte_enable   = 4'b1111;

        unique case (state_q)
            StFetch1: load_mar = 1'b1;
            StFetch2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            StFetch3: load_ir = 1'b1;
            StDecode: ;
            StImm, StReg: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                alumux2_sel  = (state_q == StReg) ? 3'd5 : 3'd0;
                case (funct3)
                    3'b010: begin
                        cmpop          = CmpBlt;
                        cmpmux_sel     = (state_q == StImm);
                        regfilemux_sel = 3'd1;
                    end
                    3'b011: begin
                        cmpop          = CmpBltu;
                        cmpmux_sel     = (state_q == StImm);
                        regfilemux_sel = 3'd1;
                    end
                    3'b101:  aluop = funct7[5] ? AluSra : AluSrl;
                    // funct7 is immediate bits for addi, so only reg ops may subtract.
                    3'b000:  aluop = (state_q == StReg && funct7[5]) ? AluSub : AluAdd;
                    default: aluop = funct3;
                endcase
            end
            StBr: begin
                load_pc     = 1'b1;
                pcmux_sel   = br_en ? 2'd1 : 2'd0;
                alumux1_sel = 1'b1;
                alumux2_sel = 3'd2;
                cmpop       = funct3;
            end
            StLui: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 3'd2;
                load_pc        = 1'b1;
            end
            StAuipc: begin
                alumux1_sel  = 1'b1;
                alumux2_sel  = 3'd1;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
            end
            StJal: begin
                alumux1_sel    = 1'b1;
                alumux2_sel    = 3'd4;
                pcmux_sel      = 2'd1;
                load_pc        = 1'b1;
                regfilemux_sel = 3'd4;
                load_regfile   = 1'b1;
            end
            StJalr: begin
                pcmux_sel      = 2'd2;
                load_pc        = 1'b1;
                regfilemux_sel = 3'd4;
                load_regfile   = 1'b1;
            end
            StCalcAddr: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                if (opcode == OpStore) begin
                    alumux2_sel       = 3'd3;
                    load_mem_data_out = 1'b1;
                end
            end
            StLd1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            StLd2: begin
                regfilemux_sel = 3'd3;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
            end
            StSt1: begin
                mem_write = 1'b1;
                case (funct3)
                    3'b000:  mem_byte_enable = 4'b0001 << mem_addr_lo;
                    3'b001:  mem_byte_enable = 4'b0011 << {mem_addr_lo[1], 1'b0};
                    default: mem_byte_enable = 4'b1111;
                endcase
            end
            StSt2: load_pc = 1'b1;
            StNop: load_pc = 1'b1;
            default: ;
        endcase

        if (!rst_n) begin
            pcmux_sel         = 2'd0;
            load_pc           = 1'b0;
            cmpmux_sel        = 1'b0;
            marmux_sel        = 1'b0;
            alumux1_sel       = 1'b0;
            alumux2_sel       = 3'd0;
            regfilemux_sel    = 3'd0;
            aluop             = 3'd0;
            cmpop             = 3'd0;
            load_mar          = 1'b0;
            load_mdr          = 1'b0;
            load_ir           = 1'b0;
            load_regfile      = 1'b0;
            load_mem_data_out = 1'b0;
            mem_read          = 1'b0;
            mem_write         = 1'b0;
            mem_byte_enable   = 4'b0000;
        end
    end

    assign instret = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: per-instruction cycle schedule model with a
// negedge compare process, plus literal spot checks on key cycles.
module tb_cpu_control;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [1:0] pcmux;
        logic       load_pc;
        logic       cmpmux;
        logic       marmux;
        logic       alumux1;
        logic [2:0] alumux2;
        logic [2:0] rfmux;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       load_mar;
        logic       load_mdr;
        logic       load_ir;
        logic       load_regfile;
        logic       load_mdo;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] be;
    } ctrl_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          br_en;
    logic          mem_resp;
    logic [1:0]    mem_addr_lo;
    logic [1:0]    pcmux_sel;
    logic          load_pc, cmpmux_sel, marmux_sel, alumux1_sel;
    logic [2:0]    alumux2_sel, regfilemux_sel, aluop, cmpop;
    logic          load_mar, load_mdr, load_ir, load_regfile, load_mem_data_out;
    logic          mem_read, mem_write;
    logic [3:0]    mem_byte_enable;
    logic [CW-1:0] instret;

    cpu_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_resp(mem_resp), .mem_addr_lo(mem_addr_lo),
        .pcmux_sel(pcmux_sel), .load_pc(load_pc), .cmpmux_sel(cmpmux_sel),
        .marmux_sel(marmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .aluop(aluop), .cmpop(cmpop),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mem_data_out(load_mem_data_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .instret(instret)
    );

    always #5 clk = ~clk;

    ctrl_t act;
    assign act = {pcmux_sel, load_pc, cmpmux_sel, marmux_sel, alumux1_sel, alumux2_sel,
                  regfilemux_sel, aluop, cmpop, load_mar, load_mdr, load_ir, load_regfile,
                  load_mem_data_out, mem_read, mem_write, mem_byte_enable};

    ctrl_t         exp_q[$];
    logic [CW-1:0] cnt_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc_no = 0;
    int            model_cnt = 0;

    // Every queued cycle: full control word and instret against the model.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ctrl_t         e;
            logic [CW-1:0] c;
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL ctrl cycle %0d: got %h required %h", cyc_no, act, e);
            end
            n_cmp++;
            if (instret !== c) begin
                n_bad++;
                $display("FAIL instret cycle %0d: got %0d required %0d", cyc_no, instret, c);
            end
            cyc_no++;
        end
    end

    function automatic ctrl_t idle_word();
        ctrl_t w;
        w    = '0;
        w.be = 4'b1111;
        return w;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] alo);
        if (f3 == 3'd0) return 4'(1 << alo);
        if (f3 == 3'd1) return (alo >= 2'd2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Execute-cycle word for every non-memory opcode, straight from the instruction rules.
    function automatic ctrl_t exec_word(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic br);
        ctrl_t w;
        logic  is_reg;
        w = idle_word();
        w.load_pc = 1'b1;
        is_reg = (op == 7'h33);
        if (op == 7'h13 || is_reg) begin
            w.load_regfile = 1'b1;
            w.alumux2      = is_reg ? 3'd5 : 3'd0;
            if (f3 == 3'd2 || f3 == 3'd3) begin
                w.cmpop  = (f3 == 3'd2) ? 3'd4 : 3'd6;
                w.cmpmux = !is_reg;
                w.rfmux  = 3'd1;
            end else if (f3 == 3'd5) begin
                w.aluop = f7[5] ? 3'd2 : 3'd5;
            end else if (f3 == 3'd0) begin
                w.aluop = (is_reg && f7[5]) ? 3'd3 : 3'd0;
            end else begin
                w.aluop = f3;
            end
        end else if (op == 7'h63) begin
            w.pcmux   = br ? 2'd1 : 2'd0;
            w.alumux1 = 1'b1;
            w.alumux2 = 3'd2;
            w.cmpop   = f3;
        end else if (op == 7'h37) begin
            w.load_regfile = 1'b1;
            w.rfmux        = 3'd2;
        end else if (op == 7'h17) begin
            w.alumux1      = 1'b1;
            w.alumux2      = 3'd1;
            w.load_regfile = 1'b1;
        end else if (op == 7'h6F) begin
            w.alumux1      = 1'b1;
            w.alumux2      = 3'd4;
            w.pcmux        = 2'd1;
            w.rfmux        = 3'd4;
            w.load_regfile = 1'b1;
        end else if (op == 7'h67) begin
            w.pcmux        = 2'd2;
            w.rfmux        = 3'd4;
            w.load_regfile = 1'b1;
        end
        return w;
    endfunction

    task automatic cyc(input ctrl_t w, input logic resp);
        mem_resp = resp;
        exp_q.push_back(w);
        cnt_q.push_back(CW'(model_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input ctrl_t w, input logic resp);
        mem_resp = resp;
        exp_q.push_back(w);
        cnt_q.push_back(CW'(model_cnt));
        model_cnt = (model_cnt + 1) % (1 << CW);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int unsigned val);
        int unsigned got;
        case (name)
            "aluop": got = 32'(aluop);
            "cmpop": got = 32'(cmpop);
            "be":    got = 32'(mem_byte_enable);
            "pcmux": got = 32'(pcmux_sel);
            "rfmux": got = 32'(regfilemux_sel);
            default: return;
        endcase
        n_cmp++;
        if (got !== val) begin
            n_bad++;
            $display("FAIL lit %s: got %0d required %0d", name, got, val);
        end
    endtask

    task automatic lit_cnt(input string name, input int unsigned val);
        n_cmp++;
        if (32'(instret) !== val) begin
            n_bad++;
            $display("FAIL %s: instret got %0d required %0d", name, instret, val);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic br, input logic [1:0] alo, input int flat,
                             input int mlat, input logic noise, input string lname,
                             input int unsigned lval);
        ctrl_t w, b;
        logic  is_ld, is_st;
        opcode = op; funct3 = f3; funct7 = f7; br_en = br; mem_addr_lo = alo;
        b = idle_word();
        w = b; w.load_mar = 1'b1;
        cyc(w, noise);
        for (int i = 0; i <= flat; i++) begin
            w = b; w.mem_read = 1'b1; w.load_mdr = 1'b1;
            cyc(w, i == flat);
        end
        w = b; w.load_ir = 1'b1;
        cyc(w, noise);
        cyc(b, noise);
        is_ld = (op == 7'h03);
        is_st = (op == 7'h23);
        if (is_ld || is_st) begin
            w = b; w.marmux = 1'b1; w.load_mar = 1'b1;
            w.alumux2 = is_st ? 3'd3 : 3'd0; w.load_mdo = is_st;
            cyc(w, noise);
            for (int i = 0; i <= mlat; i++) begin
                w = b;
                if (is_ld) begin
                    w.mem_read = 1'b1; w.load_mdr = 1'b1;
                end else begin
                    w.mem_write = 1'b1; w.be = store_be(f3, alo);
                end
                if (i == 0 && is_st) lit(lname, lval);
                cyc(w, i == mlat);
            end
            w = b; w.load_pc = 1'b1;
            if (is_ld) begin
                w.rfmux = 3'd3; w.load_regfile = 1'b1;
                lit(lname, lval);
            end
            retire(w, noise);
        end else begin
            lit(lname, lval);
            retire(exec_word(op, f3, f7, br), noise);
        end
    endtask

    initial begin
        ctrl_t z, w;
        z = '0;
        rst_n = 1'b0; mem_resp = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        br_en = 1'b0; mem_addr_lo = '0;
        @(posedge clk);
        #1;
        cyc(z, 1'b0);
        rst_n = 1'b1;

        //        op     f3    f7     br    alo  fl ml noise lit      val
        run_instr(7'h13, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "aluop", 0);
        lit_cnt("after_addi", 1);
        run_instr(7'h63, 3'd0, 7'h00, 1'b1, 2'd0, 0, 0, 1'b0, "pcmux", 1);
        run_instr(7'h63, 3'd0, 7'h00, 1'b0, 2'd0, 1, 0, 1'b0, "pcmux", 0);
        lit_cnt("after_beq", 3);
        run_instr(7'h13, 3'd5, 7'h20, 1'b0, 2'd0, 0, 0, 1'b0, "aluop", 2);
        run_instr(7'h13, 3'd3, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "cmpop", 6);
        run_instr(7'h23, 3'd0, 7'h00, 1'b0, 2'd2, 0, 1, 1'b0, "be", 4'b0100);
        run_instr(7'h23, 3'd1, 7'h00, 1'b0, 2'd2, 0, 0, 1'b0, "be", 4'b1100);
        run_instr(7'h23, 3'd2, 7'h00, 1'b0, 2'd1, 0, 2, 1'b1, "be", 4'b1111);
        run_instr(7'h03, 3'd2, 7'h00, 1'b0, 2'd0, 0, 3, 1'b0, "rfmux", 3);
        run_instr(7'h37, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b1, "rfmux", 2);
        run_instr(7'h17, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "none", 0);
        run_instr(7'h6F, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "pcmux", 1);
        run_instr(7'h67, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "pcmux", 2);
        run_instr(7'h33, 3'd0, 7'h20, 1'b0, 2'd0, 0, 0, 1'b0, "aluop", 3);
        run_instr(7'h33, 3'd2, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "cmpop", 4);
        run_instr(7'h33, 3'd5, 7'h00, 1'b0, 2'd0, 0, 0, 1'b0, "aluop", 5);
        run_instr(7'h13, 3'd4, 7'h00, 1'b0, 2'd0, 2, 0, 1'b1, "aluop", 4);
        lit_cnt("after_wrap", 1);

        // Reset in the middle of a fetch wait, with mem_resp arriving in the same cycle.
        opcode = 7'h13;
        w = idle_word(); w.load_mar = 1'b1;
        cyc(w, 1'b0);
        w = idle_word(); w.mem_read = 1'b1; w.load_mdr = 1'b1;
        cyc(w, 1'b0);
        rst_n = 1'b0;
        model_cnt = 0;
        cyc(z, 1'b1);
        rst_n = 1'b1;
        lit_cnt("after_reset", 0);
        run_instr(7'h7F, 3'd0, 7'h00, 1'b0, 2'd0, 0, 0, 1'b1, "pcmux", 0);
        lit_cnt("after_nop", 1);

        mem_resp = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
